// File: rtl/trackball_quad_if.sv
// Mouse-to-trackball bus: packet and control inputs in, quadrature-style step outputs back.
interface trackball_quad_if #(
    parameter int unsigned DIV_W = 3
);
    logic [24:0]      mouse_i;
    logic [DIV_W-1:0] sense_i;
    logic             flip_i;
    logic             x_dir_o;
    logic             x_clk_o;
    logic             y_dir_o;
    logic             y_clk_o;
    logic [7:0]       trakball_o;
    logic             idle_o;

    modport master (
        output mouse_i, sense_i, flip_i,
        input  x_dir_o, x_clk_o, y_dir_o, y_clk_o, trakball_o, idle_o
    );

    modport slave (
        input  mouse_i, sense_i, flip_i,
        output x_dir_o, x_clk_o, y_dir_o, y_clk_o, trakball_o, idle_o
    );
endinterface

// File: rtl/trackball_quad.sv
// PS/2 mouse packets -> Centipede trackball dir/step-clock pairs.
// Motion is summed into saturating per-axis accumulators that drain one step per rate tick.
module trackball_quad #(
    parameter int unsigned ACC_W = 12,
    parameter int unsigned DIV_W = 3
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    trackball_quad_if.slave bus
);
    localparam int unsigned DLT_W = ACC_W + 1;
    localparam int unsigned SUM_W = ACC_W + 2;
    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] ACC_MIN = ~ACC_MAX;

    typedef enum logic {ST_PRIME, ST_RUN} state_e;

    state_e                  state_q, state_d;
    logic                    old_tog_q, old_tog_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic signed [ACC_W-1:0] acc_x_q, acc_x_d;
    logic signed [ACC_W-1:0] acc_y_q, acc_y_d;
    logic                    x_dir_q, x_dir_d, x_clk_q, x_clk_d;
    logic                    y_dir_q, y_dir_d, y_clk_q, y_clk_d;
    logic                    idle_q, idle_d;
    logic                    evt;
    logic                    tick;
    logic                    unused_mouse_bits;

    assign unused_mouse_bits = ^{bus.mouse_i[7:6], bus.mouse_i[3:0]};

    assign evt  = (state_q == ST_RUN) && (bus.mouse_i[24] != old_tog_q);
    assign tick = (div_q == bus.sense_i);

    // acc + optional drain step + optional packet delta, clamped instead of wrapping
    function automatic logic signed [ACC_W-1:0] acc_update(
        input logic signed [ACC_W-1:0] acc,
        input logic                    sgn,
        input logic [7:0]              mag,
        input logic                    flip,
        input logic                    ev,
        input logic                    tk
    );
        logic signed [DLT_W-1:0] delta;
        logic signed [SUM_W-1:0] d_term;
        logic signed [SUM_W-1:0] s_term;
        logic signed [SUM_W-1:0] sum;
        logic signed [ACC_W-1:0] res;
        delta = DLT_W'($signed({sgn, mag}));
        if (flip) begin
            delta = -delta;
        end
        d_term = '0;
        if (ev) begin
            d_term = SUM_W'(delta);
        end
        s_term = '0;
        if (tk && (acc != '0)) begin
            s_term = acc[ACC_W-1] ? SUM_W'(1) : '1;
        end
        sum = SUM_W'(acc) + d_term + s_term;
        res = sum[ACC_W-1:0];
        if (sum > ACC_MAX) begin
            res = ACC_MAX[ACC_W-1:0];
        end else if (sum < ACC_MIN) begin
            res = ACC_MIN[ACC_W-1:0];
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        old_tog_d = bus.mouse_i[24];
        div_d     = div_q + DIV_W'(1);
        x_dir_d   = x_dir_q;
        x_clk_d   = x_clk_q;
        y_dir_d   = y_dir_q;
        y_clk_d   = y_clk_q;

        // first edge after reset only samples the toggle so a held bit is not an event
        if (state_q == ST_PRIME) begin
            state_d = ST_RUN;
        end

        if (tick) begin
            div_d = '0;
            if (acc_x_q != '0) begin
                x_dir_d = ~acc_x_q[ACC_W-1];
                x_clk_d = ~x_clk_q;
            end
            if (acc_y_q != '0) begin
                y_dir_d = ~acc_y_q[ACC_W-1];
                y_clk_d = ~y_clk_q;
            end
        end

        acc_x_d = acc_update(acc_x_q, bus.mouse_i[4], bus.mouse_i[15:8],
                             bus.flip_i, evt, tick);
        acc_y_d = acc_update(acc_y_q, bus.mouse_i[5], bus.mouse_i[23:16],
                             bus.flip_i, evt, tick);
        idle_d  = (acc_x_d == '0) && (acc_y_d == '0);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_PRIME;
            old_tog_q <= 1'b0;
            div_q     <= '0;
            acc_x_q   <= '0;
            acc_y_q   <= '0;
            x_dir_q   <= 1'b0;
            x_clk_q   <= 1'b0;
            y_dir_q   <= 1'b0;
            y_clk_q   <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            old_tog_q <= old_tog_d;
            div_q     <= div_d;
            acc_x_q   <= acc_x_d;
            acc_y_q   <= acc_y_d;
            x_dir_q   <= x_dir_d;
            x_clk_q   <= x_clk_d;
            y_dir_q   <= y_dir_d;
            y_clk_q   <= y_clk_d;
            idle_q    <= idle_d;
        end
    end

    assign bus.x_dir_o    = x_dir_q;
    assign bus.x_clk_o    = x_clk_q;
    assign bus.y_dir_o    = y_dir_q;
    assign bus.y_clk_o    = y_clk_q;
    assign bus.trakball_o = {x_dir_q, x_dir_q, x_clk_q, x_clk_q,
                             y_dir_q, y_dir_q, y_clk_q, y_clk_q};
    assign bus.idle_o     = idle_q;
endmodule

// File: tb/tb_trackball_quad.sv
// Scoreboard bench for trackball_quad: each packet queues its expected steps, the monitor pops one per clock toggle.
module tb_trackball_quad;
    localparam int unsigned DIV_W = 3;

    typedef struct {
        logic dir;
        int   gap;
    } step_t;

    logic clk;
    logic rst_n;

    trackball_quad_if #(.DIV_W(DIV_W)) bus ();

    trackball_quad #(.ACC_W(12), .DIV_W(DIV_W)) dut (
        .clk_sys (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    step_t xq[$];
    step_t yq[$];
    step_t mon_e;
    int    n_chk  = 0;
    int    n_fail = 0;
    int    cyc    = 0;
    int    last_x = 0;
    int    last_y = 0;
    logic  exp_xclk = 1'b0;
    logic  exp_yclk = 1'b0;
    logic  prev_x   = 1'b0;
    logic  prev_y   = 1'b0;
    logic  mon_en   = 1'b0;
    logic  tog      = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Monitor: every observed clock-line edge consumes one expected step
    always @(posedge clk) begin
        #1;
        if (!rst_n || !mon_en) begin
            exp_xclk = 1'b0;
            exp_yclk = 1'b0;
            prev_x   = 1'b0;
            prev_y   = 1'b0;
        end else begin
            if (bus.x_clk_o !== prev_x) begin
                if (xq.size() > 0) begin
                    mon_e    = xq.pop_front();
                    exp_xclk = ~exp_xclk;
                    check("x_dir", bus.x_dir_o, mon_e.dir);
                    if (mon_e.gap != 0) check("x_gap", cyc - last_x, mon_e.gap);
                    check("x_trak", bus.trakball_o[7:4], {{2{mon_e.dir}}, {2{exp_xclk}}});
                end
                check("x_clk", bus.x_clk_o, exp_xclk);
                last_x = cyc;
                prev_x = bus.x_clk_o;
            end
            if (bus.y_clk_o !== prev_y) begin
                if (yq.size() > 0) begin
                    mon_e    = yq.pop_front();
                    exp_yclk = ~exp_yclk;
                    check("y_dir", bus.y_dir_o, mon_e.dir);
                    if (mon_e.gap != 0) check("y_gap", cyc - last_y, mon_e.gap);
                    check("y_trak", bus.trakball_o[3:0], {{2{mon_e.dir}}, {2{exp_yclk}}});
                end
                check("y_clk", bus.y_clk_o, exp_yclk);
                last_y = cyc;
                prev_y = bus.y_clk_o;
            end
        end
    end

    task automatic push_x(input int n, input logic dir, input int gap);
        step_t s;
        for (int i = 0; i < n; i++) begin
            s.dir = dir;
            s.gap = (i == 0) ? 0 : gap;
            xq.push_back(s);
        end
    endtask

    task automatic push_y(input int n, input logic dir, input int gap);
        step_t s;
        for (int i = 0; i < n; i++) begin
            s.dir = dir;
            s.gap = (i == 0) ? 0 : gap;
            yq.push_back(s);
        end
    endtask

    // Called on a negedge; returns on the negedge after the packet was sampled
    task automatic send(input logic [7:0] dx, input logic xs,
                        input logic [7:0] dy, input logic ys);
        tog = ~tog;
        bus.mouse_i = {tog, dy, dx, 2'b00, ys, xs, 4'h0};
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        xq.delete();
        yq.delete();
        #1;
        check("rst_trak", bus.trakball_o, 8'h00);
        check("rst_idle", bus.idle_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int k;
        k = 0;
        while ((xq.size() != 0 || yq.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
        check({tag, "_xq_left"}, xq.size(), 0);
        check({tag, "_yq_left"}, yq.size(), 0);
        check({tag, "_idle"}, bus.idle_o, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b1;
        bus.mouse_i = '0;
        bus.sense_i = '0;
        bus.flip_i  = 1'b0;
        @(negedge clk);
        pulse_reset();
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // +5 on X at full rate
        check("t1_idle_pre", bus.idle_o, 1);
        push_x(5, 1'b1, 1);
        send(8'd5, 1'b0, 8'd0, 1'b0);
        check("t1_busy", bus.idle_o, 0);
        drain("t1", 100);
        check("t1_xclk", bus.x_clk_o, 1);
        check("t1_ydir", bus.y_dir_o, 0);
        check("t1_yclk", bus.y_clk_o, 0);

        // -5 flipped becomes +5, then unflipped -5
        bus.flip_i = 1'b1;
        push_x(5, 1'b1, 1);
        send(8'hFB, 1'b1, 8'd0, 1'b0);
        drain("t2a", 100);
        check("t2a_xclk", bus.x_clk_o, 0);
        bus.flip_i = 1'b0;
        push_x(5, 1'b0, 1);
        send(8'hFB, 1'b1, 8'd0, 1'b0);
        drain("t2b", 100);
        check("t2b_xdir", bus.x_dir_o, 0);
        check("t2b_xclk", bus.x_clk_o, 1);

        // +3 on Y with one tick every 4 cycles
        bus.sense_i = DIV_W'(3);
        push_y(3, 1'b1, 4);
        send(8'd0, 1'b0, 8'd3, 1'b0);
        drain("t3", 100);
        check("t3_trak", bus.trakball_o, 8'h3F);

        // saturation: 20 x +127 at sense 7 from a known divider phase
        bus.sense_i = DIV_W'(7);
        pulse_reset();
        repeat (9) @(negedge clk);
        push_x(2049, 1'b1, 8);
        for (int i = 0; i < 20; i++) send(8'd127, 1'b0, 8'd0, 1'b0);
        drain("t4", 20000);
        check("t4_xdir", bus.x_dir_o, 1);
        check("t4_xclk", bus.x_clk_o, 1);

        // reset in the middle of a 100-step drain
        bus.sense_i = '0;
        push_x(100, 1'b1, 1);
        send(8'd100, 1'b0, 8'd0, 1'b0);
        repeat (30) @(negedge clk);
        check("t5_busy", bus.idle_o, 0);
        pulse_reset();
        repeat (150) @(negedge clk);
        check("t5_idle", bus.idle_o, 1);
        check("t5_trak", bus.trakball_o, 8'h00);
        check("t5_xq_left", xq.size(), 0);

        // toggle held high across reset release is not a packet
        tog = 1'b1;
        bus.mouse_i = {1'b1, 8'd0, 8'd10, 8'h00};
        pulse_reset();
        repeat (30) @(negedge clk);
        check("t6_idle", bus.idle_o, 1);
        check("t6_xclk", bus.x_clk_o, 0);
        push_x(2, 1'b1, 1);
        send(8'd2, 1'b0, 8'd0, 1'b0);
        drain("t6", 100);
        check("t6_xclk_end", bus.x_clk_o, 0);
        check("t6_xdir", bus.x_dir_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/trackball_quad.md
Name: trackball_quad

Overview:
- Converts MiSTer PS/2 mouse packets into the Centipede trackball inputs: X/Y direction plus step-clock pairs feeding the core's 8-bit trackball input.
- Runs upstream of the game core in clk_sys (12 MHz) and replaces the ad-hoc mouse-delay logic at top level.
- Each packet's motion is summed into a signed per-axis accumulator.
- The accumulators drain toward zero at one step per rate tick; each step toggles that axis's clock line.

Parameters:
- ACC_W, 12, accumulator width per axis (signed two's complement).
- DIV_W, 3, width of the rate divider counter and of sense_i.

Ports:
- clk_sys  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- mouse_i  input  25  hps_io mouse packet: [24] event toggle, [23:16] dy magnitude byte, [15:8] dx magnitude byte, [5] y sign, [4] x sign.
- sense_i  input  DIV_W  rate select; one tick every sense_i+1 cycles.
- flip_i  input  1  cocktail control flip; negates both deltas.
- x_dir_o  output  1  X direction: 1 = accumulator positive, 0 = negative.
- x_clk_o  output  1  X step clock; toggles once per X step.
- y_dir_o  output  1  Y direction.
- y_clk_o  output  1  Y step clock.
- trakball_o  output  8  {x_dir,x_dir,x_clk,x_clk,y_dir,y_dir,y_clk,y_clk} to core trakball_i.
- idle_o  output  1  1 when both accumulators are zero.

Behaviour:
- Reset (async, reset_n=0):
  - accumulators = 0; divider = 0; all dir/clk outputs = 0; trakball_o = 8'h00; idle_o = 1.
  - old_toggle = 0; primed = 0.
- Priming:
  - First clk_sys edge after reset release: old_toggle <= mouse_i[24], primed <= 1, no event taken.
  - Consequence: a toggle held at 1 through reset never produces a spurious packet.
- Event detect (every cycle once primed): event = mouse_i[24] != old_toggle; old_toggle updated every cycle.
- Delta per axis:
  - 9-bit signed {sign, byte}, sign-extended to ACC_W+1.
  - If flip_i=1, delta is two's-complement negated.
- Divider:
  - tick = (div == sense_i). On tick div <= 0, else div <= div+1 (natural wrap at 2^DIV_W).
  - If sense_i is lowered below div, the next tick occurs after the wrap.
  - sense_i=0: tick every cycle.
- Step on tick, per axis, when acc != 0:
  - step = +1 if acc negative, -1 if positive.
  - dir_o <= ~acc[ACC_W-1]; clk_o toggles.
  - When acc == 0: no toggle; dir_o holds its last value.
- Accumulator next value:
  - acc_next = sat(acc + step_term + delta_term).
  - step_term = step on tick, else 0; delta_term = delta on event, else 0.
  - Computed at ACC_W+2 bits, then saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1] (default -2048..2047). No wrap ever.
- Simultaneous tick and event: both apply in the same cycle. Direction and toggle are decided from the pre-update acc.
- Latency:
  - Event at edge N updates acc at edge N.
  - The first toggle happens at the first tick edge strictly after N.
- Consistency: outputs are registered; trakball_o and idle_o are derived from registers only (no combinational input path).
- Reset mid-drain: everything returns to reset values immediately; pending motion is discarded.

Test Plan:
- Reset, sense=0, flip=0, one event dx=+5 (sign0, 8'h05) → x_dir_o=1, exactly 5 x_clk_o toggles on 5 consecutive cycles; x_clk ends at 1; then idle_o=1; Y unchanged.
- sense=0, flip=1, event dx sign=1 byte 8'hFB (-5) → treated as +5: x_dir_o=1, 5 toggles. Same with flip=0 → x_dir_o=0, 5 toggles.
- sense=3, event dy=+3 → y_clk_o toggles every 4 cycles (3 toggles spanning 12 cycles); trakball_o[1:0] follows y_clk; trakball_o[3:2]=2'b11.
- sense=7, 20 events dx=+127 on consecutive cycles → acc saturates at 2047 and never goes negative; x_dir_o stays 1; total toggles = 2047 plus drains that occurred before saturation.
- Drain of 100 in progress, pulse reset_n low 1 cycle → trakball_o=8'h00 asynchronously; no toggles after release; idle_o=1.
- mouse_i[24]=1 held across reset release with dx=+10 → zero toggles. A subsequent 1→0 toggle with dx=+2 → exactly 2 toggles.
